// File: rtl/bp_pkg.sv
// Shared helpers for the gshare predictor: counter reset constant, saturating arithmetic
// and the PC/history index hash.
package bp_pkg;

    function automatic logic [31:0] bp_weak_taken(input int unsigned ctr_bits);
        return 32'(1) << (ctr_bits - 1);
    endfunction

    function automatic logic [31:0] bp_sat_inc(input logic [31:0] v, input int unsigned ctr_bits);
        logic [31:0] max_v;
        max_v = (32'(1) << ctr_bits) - 32'(1);
        return (v >= max_v) ? max_v : v + 32'(1);
    endfunction

    function automatic logic [31:0] bp_sat_dec(input logic [31:0] v);
        return (v == 32'(0)) ? 32'(0) : v - 32'(1);
    endfunction

    // Word-aligned PC bits XORed with the zero-extended history; caller truncates to index width.
    function automatic logic [31:0] bp_hash(input logic [31:0] pc_word, input logic [31:0] hist);
        return pc_word ^ hist;
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Saturating counter array: one combinational read port, one read-before-write update port.
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0]   rd_ctr,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_taken
);

    localparam int unsigned Depth = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0] WeakTaken = CTR_BITS'(bp_weak_taken(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q [Depth];
    logic [CTR_BITS-1:0] wr_cur;
    logic [CTR_BITS-1:0] wr_new;

    // The write lands at the clock edge, so a same-cycle read sees the old value.
    assign rd_ctr = ctr_q[rd_idx];
    assign wr_cur = ctr_q[wr_idx];

    always_comb begin
        wr_new = wr_cur;
        if (wr_taken) begin
            wr_new = CTR_BITS'(bp_sat_inc(32'(wr_cur), CTR_BITS));
        end else begin
            wr_new = CTR_BITS'(bp_sat_dec(32'(wr_cur)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                ctr_q[i] <= WeakTaken;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= wr_new;
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with speculative GHR and mispredict recovery.
// Define BP_STATS_EN to add branch/mispredict counters on stat_branches/stat_mispredicts.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 12,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned HIST_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  pc_in,
    input  logic                 fetch_valid,
    input  logic                 btb_hit,
    output logic                 predict_taken,
    output logic [HIST_BITS-1:0] ghr_snapshot,
    input  logic [PC_WIDTH-1:0]  ex_mem_pc_in,
    input  logic                 update_bht,
    input  logic                 actual_taken,
    input  logic [HIST_BITS-1:0] update_ghr_snapshot,
`ifdef BP_STATS_EN
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts,
`endif
    input  logic                 mispredict
);

    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [CTR_BITS-1:0]   rd_ctr;
    logic [HIST_BITS:0]    fetch_shift, recover_shift;

    assign rd_idx = INDEX_BITS'(bp_hash(32'(pc_in[INDEX_BITS+1:2]), 32'(ghr_q)));
    assign wr_idx = INDEX_BITS'(bp_hash(32'(ex_mem_pc_in[INDEX_BITS+1:2]),
                                        32'(update_ghr_snapshot)));

    bp_sat_counter_table #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_BITS   (CTR_BITS)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (rd_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (update_bht),
        .wr_idx   (wr_idx),
        .wr_taken (actual_taken)
    );

    assign predict_taken = !reset && btb_hit && rd_ctr[CTR_BITS-1];
    assign ghr_snapshot  = ghr_q;

    // One extra bit on the left lets HIST_BITS = 1 drop the old history cleanly.
    assign fetch_shift   = {ghr_q, predict_taken};
    assign recover_shift = {update_ghr_snapshot, actual_taken};

    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = recover_shift[HIST_BITS-1:0];
        end else if (fetch_valid && btb_hit) begin
            ghr_d = fetch_shift[HIST_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (update_bht) begin
            stat_br_q <= stat_br_q + 32'd1;
            if (mispredict) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor; stats checks built only with BP_STATS_EN.
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pc_in;
    logic        fetch_valid;
    logic        btb_hit;
    logic        predict_taken;
    logic [3:0]  ghr_snapshot;
    logic [11:0] ex_mem_pc_in;
    logic        update_bht;
    logic        actual_taken;
    logic [3:0]  update_ghr_snapshot;
    logic        mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gshare_branch_predictor #(
        .PC_WIDTH   (12),
        .INDEX_BITS (4),
        .CTR_BITS   (2),
        .HIST_BITS  (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .pc_in               (pc_in),
        .fetch_valid         (fetch_valid),
        .btb_hit             (btb_hit),
        .predict_taken       (predict_taken),
        .ghr_snapshot        (ghr_snapshot),
        .ex_mem_pc_in        (ex_mem_pc_in),
        .update_bht          (update_bht),
        .actual_taken        (actual_taken),
        .update_ghr_snapshot (update_ghr_snapshot),
`ifdef BP_STATS_EN
        .stat_branches       (stat_branches),
        .stat_mispredicts    (stat_mispredicts),
`endif
        .mispredict          (mispredict)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Expected predict_taken after each training pulse on index 4 (counter 2 at start).
    // Not-taken x3: 1,0,0 ; taken x4: 1,2,3,3 ; not-taken x2: 2,1.
    logic       train_dir [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic       train_exp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        reset = 1'b1; pc_in = 12'h010; fetch_valid = 1'b0; btb_hit = 1'b1;
        ex_mem_pc_in = 12'h010; update_bht = 1'b0; actual_taken = 1'b0;
        update_ghr_snapshot = 4'h0; mispredict = 1'b0;
        step();
        step();
        check("rst_pt_forced", 32'(predict_taken), 32'd0);
        check("rst_ghr", 32'(ghr_snapshot), 32'd0);
        reset = 1'b0;

        // 1: reset counter is weakly taken
        settle();
        check("t1_pt_hit", 32'(predict_taken), 32'd1);
        btb_hit = 1'b0;
        settle();
        check("t1_pt_nohit", 32'(predict_taken), 32'd0);

        // 2: training and saturation on index 4
        btb_hit = 1'b1;
        for (int i = 0; i < 9; i++) begin
            update_bht = 1'b1;
            actual_taken = train_dir[i];
            step();
            update_bht = 1'b0;
            settle();
            check($sformatf("t2_train%0d", i), 32'(predict_taken), 32'(train_exp[i]));
        end
        check("t2_ghr_hold", 32'(ghr_snapshot), 32'd0);

        // 3: speculative GHR shift from fresh counters
        do_reset();
        fetch_valid = 1'b1;
        settle();
        check("t3_ghr0", 32'(ghr_snapshot), 32'h0);
        step();
        check("t3_ghr1", 32'(ghr_snapshot), 32'h1);
        check("t3_pt_idx5", 32'(predict_taken), 32'd1);
        step();
        check("t3_ghr2", 32'(ghr_snapshot), 32'h3);

        // 4: mispredict restore wins over fetch shift
        mispredict = 1'b1;
        update_ghr_snapshot = 4'b0101;
        actual_taken = 1'b0;
        step();
        mispredict = 1'b0;
        check("t4_restore", 32'(ghr_snapshot), 32'hA);
        fetch_valid = 1'b1;
        btb_hit = 1'b0;
        step();
        check("t4_hold_nohit", 32'(ghr_snapshot), 32'hA);
        // pc 0x000 ^ GHR 0xA -> index 10, untouched by mispredict without update
        btb_hit = 1'b1; fetch_valid = 1'b0; pc_in = 12'h000;
        settle();
        check("t4_no_train", 32'(predict_taken), 32'd1);

        // 5: read-before-write collision on index 4
        do_reset();
        pc_in = 12'h010; ex_mem_pc_in = 12'h010; update_ghr_snapshot = 4'h0;
        update_bht = 1'b1; actual_taken = 1'b0;
        settle();
        check("t5_pre_update", 32'(predict_taken), 32'd1);
        step();
        update_bht = 1'b0;
        settle();
        check("t5_post_update", 32'(predict_taken), 32'd0);

        // Update index uses the snapshot: pc 0x010 ^ 1 -> index 5
        update_ghr_snapshot = 4'h1;
        update_bht = 1'b1;
        step();
        step();
        update_bht = 1'b0;
        pc_in = 12'h014;
        settle();
        check("hash_idx5", 32'(predict_taken), 32'd0);
        pc_in = 12'h018;
        settle();
        check("hash_idx6_untouched", 32'(predict_taken), 32'd1);

`ifdef BP_STATS_EN
        // 6: statistics counters
        do_reset();
        update_ghr_snapshot = 4'h0;
        for (int i = 0; i < 5; i++) begin
            update_bht = 1'b1;
            mispredict = (i == 1 || i == 3);
            step();
        end
        update_bht = 1'b0; mispredict = 1'b0;
        settle();
        check("t6_branches", stat_branches, 32'd5);
        check("t6_mispredicts", stat_mispredicts, 32'd2);
        mispredict = 1'b1;
        step();
        mispredict = 1'b0;
        check("t6_mp_no_update", stat_mispredicts, 32'd2);
        do_reset();
        check("t6_rst_br", stat_branches, 32'd0);
        check("t6_rst_mp", stat_mispredicts, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
